imem_run_ctrl: RTL and testbench

Controller that sequences the single-cycle core around a writable instruction memory.
- Streams a program into instruction memory: load phase, words written sequentially from index 0.
- Releases the core to run, and detects the HALT encoding (ECALL) at fetch.
- On HALT, freezes the PC and gates register-file and data-memory writes.
- Supports resume past the HALT word.
- Sits between the core's fetch/PC path and the instruction memory port; it is the only owner of that port.

---
 rtl/imem_ctrl_pkg.sv | 15 +
 rtl/imem_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_run_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared encodings and constants for the instruction-memory run controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_RUN    = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [31:0] HALT_INSN_C = 32'h0000_0073;
    localparam logic [31:0] NOP_INSN_C  = 32'h0000_0013;
    localparam logic [6:0]  OPC_SYSTEM  = 7'h73;

endpackage

// File: rtl/imem_run_ctrl.sv
// Sequences program load, run, halt and resume of the single-cycle core around
// a writable instruction memory; sole owner of the memory port.
module imem_run_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] HALT_INSN = HALT_INSN_C,
    parameter logic [31:0] NOP_INSN  = NOP_INSN_C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_i,
    output logic [31:0]       fetch_instr_o,
    output logic              pc_en_o,
    output logic              wb_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic              ld_last_i,
    input  logic [31:0]       ld_data_i,
    output logic              ld_ready_o,
    input  logic              run_i,
    output logic [1:0]        state_o,
    output logic              halted_o,
    output logic              fault_o,
    output logic [ADDR_W:0]   load_count_o,
    output logic [31:0]       instr_count_o
);

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LC_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LAST_IDX = DEPTH - LC_ONE;

    state_t            state_r;
    logic [ADDR_W:0]   load_count_r;
    logic [31:0]       instr_count_r;
    logic              fault_r;
    logic              skip_r;

    logic              pc_fault_s;
    logic              halt_word_s;
    logic              halt_hit_s;
    logic              ld_ready_s;
    logic              beat_s;
    logic              retire_s;

    // An unaligned PC or one beyond the memory window cannot be fetched.
    assign pc_fault_s  = (pc_i[1:0] != 2'b00) || (pc_i[31:ADDR_W+2] != '0);
    assign halt_word_s = (mem_rdata_i == HALT_INSN);
    assign halt_hit_s  = halt_word_s && !skip_r;
    assign ld_ready_s  = (state_r == ST_LOAD) && (load_count_r < DEPTH);
    assign beat_s      = ld_valid_i && ld_ready_s;
    assign retire_s    = (state_r == ST_RUN) && !pc_fault_s && !halt_hit_s;

    // Same-cycle steering of the memory port and the core enables.
    always_comb begin
        fetch_instr_o = NOP_INSN;
        pc_en_o       = 1'b0;
        wb_en_o       = 1'b0;
        mem_addr_o    = pc_i[ADDR_W+1:2];
        mem_wdata_o   = ld_data_i;
        mem_we_o      = 1'b0;
        case (state_r)
            ST_LOAD: begin
                mem_addr_o = load_count_r[ADDR_W-1:0];
                mem_we_o   = beat_s;
            end
            ST_RUN: begin
                if (retire_s) begin
                    // A resumed HALT word is stepped over as a NOP.
                    fetch_instr_o = halt_word_s ? NOP_INSN : mem_rdata_i;
                    pc_en_o       = 1'b1;
                    wb_en_o       = 1'b1;
                end else begin
                    fetch_instr_o = NOP_INSN;
                end
            end
            default: begin
                fetch_instr_o = NOP_INSN;
            end
        endcase
    end

    assign ld_ready_o    = ld_ready_s;
    assign state_o       = state_r;
    assign halted_o      = (state_r == ST_HALTED);
    assign fault_o       = fault_r;
    assign load_count_o  = load_count_r;
    assign instr_count_o = instr_count_r;

    // Control state machine with load/retire counters and sticky fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            load_count_r  <= '0;
            instr_count_r <= 32'd0;
            fault_r       <= 1'b0;
            skip_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ld_start_i) begin
                        state_r       <= ST_LOAD;
                        load_count_r  <= '0;
                        instr_count_r <= 32'd0;
                        fault_r       <= 1'b0;
                        skip_r        <= 1'b0;
                    end else if (run_i) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (beat_s) begin
                        load_count_r <= load_count_r + LC_ONE;
                        if (ld_last_i || (load_count_r == LAST_IDX)) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    skip_r <= 1'b0;
                    if (pc_fault_s) begin
                        fault_r <= 1'b1;
                        state_r <= ST_HALTED;
                    end else if (halt_hit_s) begin
                        state_r <= ST_HALTED;
                    end else if (instr_count_r != 32'hFFFF_FFFF) begin
                        instr_count_r <= instr_count_r + 32'd1;
                    end
                end
                ST_HALTED: begin
                    if (ld_start_i) begin
                        state_r       <= ST_LOAD;
                        load_count_r  <= '0;
                        instr_count_r <= 32'd0;
                        fault_r       <= 1'b0;
                        skip_r        <= 1'b0;
                    end else if (run_i && !fault_r) begin
                        state_r <= ST_RUN;
                        skip_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_run_ctrl.sv
// Scoreboard bench for imem_run_ctrl with a small core PC model and memory model.
module tb_imem_run_ctrl;
    import imem_ctrl_pkg::*;

    localparam int AW = 6;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_0073;

    localparam int K_STATE = 0, K_FETCH = 1, K_PCEN = 2, K_WBEN = 3, K_WE = 4,
                   K_READY = 5, K_HALTED = 6, K_FAULT = 7, K_LCNT = 8, K_ICNT = 9,
                   K_MEM = 10, K_PC = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_i;
    logic [31:0]   fetch_instr_o;
    logic          pc_en_o, wb_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_we_o;
    logic [31:0]   mem_rdata_i;
    logic          ld_start_i, ld_valid_i, ld_last_i;
    logic [31:0]   ld_data_i;
    logic          ld_ready_o;
    logic          run_i;
    logic [1:0]    state_o;
    logic          halted_o, fault_o;
    logic [AW:0]   load_count_o;
    logic [31:0]   instr_count_o;

    imem_run_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .fetch_instr_o(fetch_instr_o),
        .pc_en_o(pc_en_o), .wb_en_o(wb_en_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
        .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_last_i(ld_last_i),
        .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o), .run_i(run_i),
        .state_o(state_o), .halted_o(halted_o), .fault_o(fault_o),
        .load_count_o(load_count_o), .instr_count_o(instr_count_o)
    );

    always #5 clk = ~clk;

    // Core PC: advances by 4 when enabled, or is forced by the bench.
    logic [31:0] pc_r;
    logic        pc_load;
    logic [31:0] pc_load_val;
    always @(posedge clk) begin
        if (pc_load) pc_r <= pc_load_val;
        else if (pc_en_o) pc_r <= pc_r + 32'd4;
    end
    assign pc_i = pc_r;

    // Instruction memory; the fill leaves HALT everywhere so a runaway program stops.
    logic [31:0] imem [64];
    logic        mem_fill;
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 64; i++) imem[i] <= HALT;
        end else if (mem_we_o) begin
            imem[mem_addr_o] <= mem_wdata_o;
        end
    end
    assign mem_rdata_i = imem[mem_addr_o];

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wexp_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] ins; logic wb; } rexp_t;
    typedef struct packed { logic [3:0] kind; logic [31:0] exp; logic [5:0] idx; } sexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    sexp_t sq[$];
    int    checks = 0;
    int    failures = 0;
    logic  done = 1'b0;

    function automatic string kname(input logic [3:0] k);
        case (k)
            4'd0: return "state";    4'd1: return "fetch";   4'd2: return "pc_en";
            4'd3: return "wb_en";    4'd4: return "mem_we";  4'd5: return "ld_ready";
            4'd6: return "halted";   4'd7: return "fault";   4'd8: return "load_count";
            4'd9: return "instr_count"; 4'd10: return "mem_word"; 4'd11: return "pc";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] sample(input logic [3:0] k, input logic [5:0] idx);
        case (k)
            4'd0: return 32'(state_o);
            4'd1: return fetch_instr_o;
            4'd2: return 32'(pc_en_o);
            4'd3: return 32'(wb_en_o);
            4'd4: return 32'(mem_we_o);
            4'd5: return 32'(ld_ready_o);
            4'd6: return 32'(halted_o);
            4'd7: return 32'(fault_o);
            4'd8: return 32'(load_count_o);
            4'd9: return instr_count_o;
            4'd10: return imem[idx];
            4'd11: return pc_i;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT writes, retires, or a status check is due.
    always @(negedge clk) begin
        wexp_t w;
        rexp_t r;
        sexp_t s;
        logic [31:0] act;
        if (mem_we_o) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL imem_write unexpected addr=%0d data=%h expected=none", mem_addr_o, mem_wdata_o);
            end else begin
                w = wq.pop_front();
                if (32'(mem_addr_o) !== w.a || mem_wdata_o !== w.d) begin
                    failures++;
                    $display("FAIL imem_write actual=%0d:%h expected=%0d:%h", mem_addr_o, mem_wdata_o, w.a, w.d);
                end
            end
        end
        if (pc_en_o) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL retire unexpected pc=%h fetch=%h expected=none", pc_i, fetch_instr_o);
            end else begin
                r = rq.pop_front();
                if (pc_i !== r.pc || fetch_instr_o !== r.ins || wb_en_o !== r.wb) begin
                    failures++;
                    $display("FAIL retire actual=%h:%h:%b expected=%h:%h:%b",
                             pc_i, fetch_instr_o, wb_en_o, r.pc, r.ins, r.wb);
                end
            end
        end
        while (sq.size() > 0) begin
            s = sq.pop_front();
            act = sample(s.kind, s.idx);
            checks++;
            if (act !== s.exp) begin
                failures++;
                $display("FAIL %s actual=%h expected=%h", kname(s.kind), act, s.exp);
            end
        end
        if (done) begin
            checks++;
            if (wq.size() != 0 || rq.size() != 0) begin
                failures++;
                $display("FAIL leftover actual=%0d/%0d expected=0/0", wq.size(), rq.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input logic [31:0] exp, input int idx = 0);
        sexp_t s;
        s.kind = 4'(kind);
        s.exp  = exp;
        s.idx  = 6'(idx);
        sq.push_back(s);
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state_o == st) return;
            tick();
        end
        if (state_o != st) chk(K_STATE, 32'(st));
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic accept, input int idx);
        wexp_t w;
        ld_valid_i = 1'b1;
        ld_data_i  = d;
        ld_last_i  = last;
        if (accept) begin
            w.a = 32'(idx);
            w.d = d;
            wq.push_back(w);
        end
        tick();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic push_retire(input logic [31:0] pc, input logic [31:0] ins);
        rexp_t r;
        r.pc  = pc;
        r.ins = ins;
        r.wb  = 1'b1;
        rq.push_back(r);
    endtask

    task automatic pulse_start();
        ld_start_i = 1'b1;
        tick();
        ld_start_i = 1'b0;
    endtask

    task automatic pulse_run();
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
    endtask

    logic [31:0] prog [7];
    logic        found;

    initial begin
        prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;
        prog[3] = 32'h0190_0213; prog[4] = 32'h0640_2223; prog[5] = 32'h0000_0073;
        prog[6] = 32'h0630_0293;
        rst = 1'b1; ld_start_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0;
        ld_data_i = 32'd0; run_i = 1'b0; pc_load = 1'b1; pc_load_val = 32'd0; mem_fill = 1'b1;
        repeat (2) tick();
        chk(K_STATE, 32'd0); chk(K_FETCH, NOP); chk(K_PCEN, 32'd0); chk(K_WBEN, 32'd0);
        chk(K_WE, 32'd0); chk(K_READY, 32'd0); chk(K_HALTED, 32'd0); chk(K_FAULT, 32'd0);
        chk(K_LCNT, 32'd0); chk(K_ICNT, 32'd0);
        tick();
        rst = 1'b0; mem_fill = 1'b0; pc_load = 1'b0;
        tick();

        // Load the 7-word program.
        pulse_start();
        chk(K_STATE, 32'd1); chk(K_READY, 32'd1);
        for (int i = 0; i < 7; i++) beat(prog[i], (i == 6), 1'b1, i);
        chk(K_LCNT, 32'd7); chk(K_STATE, 32'd0);
        tick();

        // Run to the HALT at 0x14.
        for (int i = 0; i < 5; i++) push_retire(32'(i * 4), prog[i]);
        pulse_run();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (state_o == 2'b10 && pc_i == 32'h14) begin
                chk(K_PCEN, 32'd0); chk(K_WBEN, 32'd0); chk(K_FETCH, NOP);
                found = 1'b1;
            end else begin
                tick();
            end
        end
        if (!found) chk(K_PC, 32'h14);
        tick();
        wait_state(2'b11, 5);
        chk(K_HALTED, 32'd1); chk(K_ICNT, 32'd5); chk(K_PC, 32'h14);
        tick();

        // Resume past the HALT word; fill word at index 7 halts again.
        push_retire(32'h14, NOP);
        push_retire(32'h18, prog[6]);
        pulse_run();
        chk(K_FETCH, NOP); chk(K_PCEN, 32'd1);
        tick();
        chk(K_ICNT, 32'd6); chk(K_FETCH, prog[6]); chk(K_WBEN, 32'd1);
        tick();
        wait_state(2'b11, 5);
        chk(K_ICNT, 32'd7);
        tick();

        // Overflow: 66 beats without last, only 64 accepted.
        pulse_start();
        for (int i = 1; i <= 66; i++) begin
            if (i == 1 || i == 64) chk(K_READY, 32'd1);
            if (i >= 65) begin
                chk(K_READY, 32'd0); chk(K_WE, 32'd0);
            end
            beat(32'hA000_0000 + 32'(i), 1'b0, (i <= 64), i - 1);
        end
        chk(K_LCNT, 32'd64); chk(K_STATE, 32'd0);
        tick();

        // Fault on an out-of-window PC, then on an unaligned PC.
        pc_load = 1'b1; pc_load_val = 32'h100;
        tick();
        pc_load = 1'b0;
        pulse_run();
        chk(K_PCEN, 32'd0); chk(K_WBEN, 32'd0);
        tick();
        chk(K_STATE, 32'd3); chk(K_FAULT, 32'd1); chk(K_HALTED, 32'd1);
        pulse_run();
        tick();
        chk(K_STATE, 32'd3); chk(K_FAULT, 32'd1);
        pulse_start();
        chk(K_FAULT, 32'd0); chk(K_STATE, 32'd1);
        beat(32'hDEAD_0001, 1'b1, 1'b1, 0);
        pc_load = 1'b1; pc_load_val = 32'h2;
        tick();
        pc_load = 1'b0;
        pulse_run();
        chk(K_PCEN, 32'd0);
        tick();
        chk(K_FAULT, 32'd1); chk(K_STATE, 32'd3);
        pulse_start();
        chk(K_FAULT, 32'd0);
        beat(32'hDEAD_0002, 1'b1, 1'b1, 0);
        tick();

        // Reset mid-load after three beats.
        pulse_start();
        for (int i = 0; i < 3; i++) beat(32'h1111_0000 + 32'(i), 1'b0, 1'b1, i);
        #2 rst = 1'b1;
        chk(K_STATE, 32'd0); chk(K_LCNT, 32'd0); chk(K_READY, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) chk(K_MEM, 32'h1111_0000 + 32'(i), i);
        chk(K_STATE, 32'd0);
        tick();

        done = 1'b1;
        repeat (5) tick();
        $display("FAIL monitor did not finish");
        $fatal(1);
    end

endmodule
